// File: rtl/sh_disp_updater_pkg.sv
// Shared types and constants for the big-digit shadow RAM updater.
// FSM encoding plus the ASCII codes written into the character slots.
package sh_disp_updater_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_WRITE
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/sh_bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per clock after start.
// done is high in the cycle whose closing edge performs the final step.
module sh_bcd_seq #(
  parameter int VAL_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VAL_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] sh_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      sh_q  <= bin;
      bcd_q <= '0;
      cnt_q <= CW'(VAL_W);
    end else if (cnt_q != '0) begin
      bcd_q <= {adj[BW-2:0], sh_q[VAL_W-1]};
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bcd  = bcd_q;
  assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/sh_disp_updater.sv
// Round-robin numeric updater for the big-digit shadow RAM: clamps,
// converts to BCD and writes right-aligned, zero-blanked ASCII digits.
module sh_disp_updater
  import sh_disp_updater_pkg::*;
#(
  parameter int VAL_W    = 14,
  parameter int DIGITS   = 4,
  parameter int ADDR_W   = 4,
  parameter int BASE0    = 0,
  parameter int BASE1    = 5,
  parameter int BLANK_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [VAL_W-1:0]  val0,
  output logic              ack0,
  output logic              done0,
  input  logic              req1,
  input  logic [VAL_W-1:0]  val1,
  output logic              ack1,
  output logic              done1,
  output logic              busy,
  output logic              sh_ram_we,
  output logic [ADDR_W-1:0] sh_ram_addr,
  output logic [7:0]        sh_ram_data
);

  localparam int BW      = 4 * DIGITS;
  localparam int IW      = $clog2(DIGITS + 1);
  localparam int MAX_VAL = 10**DIGITS - 1;

  state_e            state_q, state_d;
  logic              slot_q, slot_d;
  logic              last_q, last_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              nz_q, nz_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              busy_q, busy_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  logic              g_any, g_sel, start, conv_done;
  logic              last_dig, blank;
  logic [VAL_W-1:0]  val_sel, val_clamp;
  logic [BW-1:0]     bcd;
  logic [3:0]        dig;
  logic [ADDR_W-1:0] base;

  assign g_any     = req0 | req1;
  assign g_sel     = (req0 && req1) ? ~last_q : req1;
  assign val_sel   = g_sel ? val1 : val0;
  assign val_clamp = (val_sel > VAL_W'(MAX_VAL)) ? VAL_W'(MAX_VAL) : val_sel;
  assign start     = (state_q == S_IDLE) && g_any;

  sh_bcd_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (val_clamp),
    .bcd   (bcd),
    .done  (conv_done)
  );

  // Most significant digit first: idx 0 selects the top nibble.
  always_comb begin
    dig = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i))
        dig = bcd[4*(DIGITS-1-i) +: 4];
    end
  end

  assign last_dig = (idx_q == IW'(DIGITS - 1));
  assign blank    = (BLANK_EN != 0) && !nz_q && (dig == 4'd0) && !last_dig;
  assign base     = slot_q ? ADDR_W'(BASE1) : ADDR_W'(BASE0);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    last_d  = last_q;
    idx_d   = idx_q;
    nz_d    = nz_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (g_any) begin
          state_d = S_CONV;
          slot_d  = g_sel;
          last_d  = g_sel;
          ack0_d  = ~g_sel;
          ack1_d  = g_sel;
        end
      end
      S_CONV: begin
        if (conv_done) begin
          state_d = S_WRITE;
          idx_d   = '0;
          nz_d    = 1'b0;
        end
      end
      S_WRITE: begin
        we_d   = 1'b1;
        addr_d = base + ADDR_W'(idx_q);
        data_d = blank ? ASCII_SPACE : ASCII_ZERO + {4'h0, dig};
        nz_d   = nz_q | (dig != 4'd0);
        idx_d  = idx_q + 1'b1;
        if (last_dig) begin
          state_d = S_IDLE;
          done0_d = ~slot_q;
          done1_d = slot_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      slot_q  <= 1'b0;
      last_q  <= 1'b1;
      idx_q   <= '0;
      nz_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      nz_q    <= nz_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign busy        = busy_q;
  assign sh_ram_we   = we_q;
  assign sh_ram_addr = addr_q;
  assign sh_ram_data = data_q;

endmodule

// File: tb/tb_sh_disp_updater.sv
// Directed plus randomized bench for sh_disp_updater with an arithmetic
// reference for digits, blanking, clamping and round-robin order.
module tb_sh_disp_updater;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [13:0] val0 = '0, val1 = '0;
  logic        ack0, ack1, done0, done1, busy, we;
  logic [3:0]  addr;
  logic [7:0]  data;

  int vectors = 0;
  int miscompares = 0;
  int lg = 1;

  sh_disp_updater dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .val0        (val0),
    .ack0        (ack0),
    .done0       (done0),
    .req1        (req1),
    .val1        (val1),
    .ack1        (ack1),
    .done1       (done1),
    .busy        (busy),
    .sh_ram_we   (we),
    .sh_ram_addr (addr),
    .sh_ram_data (data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input int v, input int i);
    int c, p;
    c = (v > 9999) ? 9999 : v;
    p = 1;
    for (int k = 0; k < 3 - i; k++) p *= 10;
    if (i < 3 && c < p) return 8'h20;
    return 8'(8'h30 + (c / p) % 10);
  endfunction

  function automatic logic [13:0] rv();
    if ($urandom_range(0, 3) == 0) return 14'($urandom_range(0, 99));
    return 14'($urandom);
  endfunction

  task automatic run_one(input int slot, input int v, input bit drop,
                         input int exp_wait);
    int w;
    bit got, early;
    w = 0;
    got = 0;
    while (!got && w < 30) begin
      @(negedge clk);
      w++;
      got = ack0 | ack1;
    end
    chk("ack_seen", 32'(got), 1);
    if (!got) return;
    chk("ack_slot", {30'd0, ack1, ack0}, slot ? 2 : 1);
    if (exp_wait > 0) chk("ack_lat", w, exp_wait);
    if (drop) begin
      if (slot == 0) begin req0 = 1'b0; val0 = 14'($urandom); end
      else begin req1 = 1'b0; val1 = 14'($urandom); end
    end
    early = 0;
    repeat (14) begin
      @(negedge clk);
      if (we | done0 | done1 | ack0 | ack1) early = 1;
    end
    chk("quiet_conv", 32'(early), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("we", 32'(we), 1);
      chk("addr", 32'(addr), (slot ? 5 : 0) + i);
      chk("data", 32'(data), 32'(exp_char(v, i)));
      chk("done", {30'd0, done1, done0}, (i == 3) ? (slot ? 2 : 1) : 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lg = 1;
  endtask

  initial begin
    #3;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {16'd0, ack0, ack1, done0, done1, busy, we, addr, data}, 0);
    rst_n = 1'b1;

    // 1: basic slot 0 update
    req0 = 1'b1; val0 = 14'd1234;
    run_one(0, 1234, 1, 1); lg = 0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_we", 32'(we), 0);

    // 2: slot 1 blanking cases
    req1 = 1'b1; val1 = 14'd7;
    run_one(1, 7, 1, -1); lg = 1;
    req1 = 1'b1; val1 = 14'd0;
    run_one(1, 0, 1, 1); lg = 1;
    req1 = 1'b1; val1 = 14'd10;
    run_one(1, 10, 1, 1); lg = 1;

    // 3: clamp
    req0 = 1'b1; val0 = 14'd16383;
    run_one(0, 16383, 1, 1); lg = 0;
    req0 = 1'b1; val0 = 14'd9999;
    run_one(0, 9999, 1, 1); lg = 0;

    // 4: both held from reset -> 0,1,0,1
    do_reset();
    req0 = 1'b1; val0 = 14'd805;
    req1 = 1'b1; val1 = 14'd3170;
    run_one(0, 805, 0, 1);
    run_one(1, 3170, 0, 1);
    run_one(0, 805, 0, 1);
    run_one(1, 3170, 0, 1);
    req0 = 1'b0; req1 = 1'b0; lg = 1;
    @(negedge clk);
    chk("rr_idle", 32'(busy), 0);

    // 5: req1 during conv, val0 changes after ack
    req0 = 1'b1; val0 = 14'd2468;
    fork
      run_one(0, 2468, 1, 1);
      begin
        repeat (6) @(negedge clk);
        req1 = 1'b1; val1 = 14'd321;
      end
    join
    run_one(1, 321, 1, 1); lg = 1;

    // 6: reset after second write
    req0 = 1'b1; val0 = 14'd5678;
    repeat (2) @(negedge clk);
    req0 = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_rst_we", 32'(we), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_we", 32'(we), 0);
    chk("rst_done", {30'd0, done1, done0}, 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; lg = 1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    req0 = 1'b1; val0 = 14'd42;
    run_one(0, 42, 1, 1); lg = 0;

    // randomized round-robin traffic
    for (int it = 0; it < 30; it++) begin
      int s;
      if (!req0 && $urandom_range(0, 1) == 1) begin req0 = 1'b1; val0 = rv(); end
      if (!req1 && $urandom_range(0, 1) == 1) begin req1 = 1'b1; val1 = rv(); end
      if (!req0 && !req1) begin req0 = 1'b1; val0 = rv(); end
      s = (req0 && req1) ? ((lg == 1) ? 0 : 1) : (req1 ? 1 : 0);
      run_one(s, s ? int'(val1) : int'(val0), 1, 1);
      lg = s;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (25) @(negedge clk);
    chk("final_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
